// File: rtl/cnn_mem_pkg.sv
// Shared types and helpers for the CNN scratch memory with streaming read port.
// CNN_MEM_PARITY_EN adds one even-parity bit per stored word.
package cnn_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        STREAM = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 256;

`ifdef CNN_MEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // Even parity: the stored bit makes the XOR of data plus parity zero.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/cnn_mem_ram.sv
// Single-port synchronous RAM, 1-cycle registered read, read-before-write.
// No reset on the array so it maps onto block RAM.
module cnn_mem_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        rdata_q <= mem[addr];
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cnn_mem_stream.sv
// CNN scratch memory: host Avalon-MM port, post-reset clear engine and a
// burst stream read port with a 2-entry output FIFO. Option: CNN_MEM_PARITY_EN.
module cnn_mem_stream
    import cnn_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              waitrequest,
    input  logic              cnn_start,
    input  logic [ADDR_W-1:0] cnn_base,
    input  logic [LEN_W-1:0]  cnn_len,
    output logic [DATA_W-1:0] cnn_data,
    output logic              cnn_valid,
    input  logic              cnn_ready,
    output logic              cnn_done,
`ifdef CNN_MEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int RAM_W = DATA_W + PAR_W;

    state_e                   state_q, state_d;
    logic [AW-1:0]            clr_ptr_q, clr_ptr_d;
    logic [AW-1:0]            strm_addr_q, strm_addr_d;
    logic [LEN_W-1:0]         issue_left_q, issue_left_d;
    logic [LEN_W-1:0]         rem_q, rem_d;
    logic [1:0][DATA_W-1:0]   fifo_mem_q, fifo_mem_d;
    logic                     fifo_wp_q, fifo_wp_d;
    logic                     fifo_rp_q, fifo_rp_d;
    logic [1:0]               fifo_cnt_q, fifo_cnt_d;
    logic                     strm_rd_q, strm_rd_d;
    logic                     host_rd_q, host_rd_d;
    logic                     host_oob_q, host_oob_d;
    logic                     done_q, done_d;

    logic              host_en, host_acc, host_wr, host_rd, in_range;
    logic              pop, issue;
    logic [1:0]        occ;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [RAM_W-1:0]  ram_wdata, ram_rdata;
    logic [DATA_W-1:0] rd_word;
    logic              base_unused;

    assign base_unused = ^cnn_base[ADDR_W-1:AW];

    assign host_en   = (state_q != CLEAR);
    assign host_acc  = host_en & chipselect & (read | write);
    assign host_wr   = host_en & chipselect & write;
    assign host_rd   = host_en & chipselect & read & ~write;
    assign in_range  = ((address >> AW) == '0);

    assign cnn_valid = (fifo_cnt_q != 2'd0);
    assign cnn_data  = fifo_mem_q[fifo_rp_q];
    assign cnn_done  = done_q;
    assign pop       = cnn_valid & cnn_ready;

    // Occupancy after this cycle's pop; counting the pop is what lets the
    // 2-entry FIFO sustain one word per cycle.
    assign occ   = fifo_cnt_q + {1'b0, strm_rd_q} - {1'b0, pop};
    assign issue = (state_q == STREAM) & ~host_acc & (issue_left_q != '0) & (occ < 2'd2);

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = strm_addr_q;
        ram_wdata = '0;
        if (state_q == CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = clr_ptr_q;
        end else if (host_wr) begin
            ram_we   = in_range;
            ram_addr = address[AW-1:0];
`ifdef CNN_MEM_PARITY_EN
            ram_wdata = {even_parity(64'(writedata)), writedata};
`else
            ram_wdata = writedata;
`endif
        end else if (host_rd) begin
            ram_addr = address[AW-1:0];
        end
    end

    cnn_mem_ram #(.WIDTH(RAM_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign rd_word       = ram_rdata[DATA_W-1:0];
    assign readdata      = (host_rd_q && !host_oob_q) ? rd_word : '0;
    assign readdatavalid = host_rd_q;
    assign waitrequest   = (state_q == CLEAR);
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        strm_addr_d  = strm_addr_q;
        issue_left_d = issue_left_q;
        rem_d        = rem_q;
        done_d       = 1'b0;
        strm_rd_d    = issue;
        host_rd_d    = host_rd;
        host_oob_d   = ~in_range;

        fifo_mem_d = fifo_mem_q;
        if (strm_rd_q) begin
            fifo_mem_d[fifo_wp_q] = rd_word;
        end
        fifo_wp_d  = fifo_wp_q ^ strm_rd_q;
        fifo_rp_d  = fifo_rp_q ^ pop;
        fifo_cnt_d = fifo_cnt_q + {1'b0, strm_rd_q} - {1'b0, pop};

        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cnn_start) begin
                    if (cnn_len != '0) begin
                        state_d      = STREAM;
                        strm_addr_d  = cnn_base[AW-1:0];
                        issue_left_d = cnn_len;
                        rem_d        = cnn_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (issue) begin
                    strm_addr_d  = strm_addr_q + AW'(1);
                    issue_left_d = issue_left_q - LEN_W'(1);
                end
                if (pop) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_ptr_q    <= '0;
            strm_addr_q  <= '0;
            issue_left_q <= '0;
            rem_q        <= '0;
            fifo_mem_q   <= '0;
            fifo_wp_q    <= 1'b0;
            fifo_rp_q    <= 1'b0;
            fifo_cnt_q   <= 2'd0;
            strm_rd_q    <= 1'b0;
            host_rd_q    <= 1'b0;
            host_oob_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            strm_addr_q  <= strm_addr_d;
            issue_left_q <= issue_left_d;
            rem_q        <= rem_d;
            fifo_mem_q   <= fifo_mem_d;
            fifo_wp_q    <= fifo_wp_d;
            fifo_rp_q    <= fifo_rp_d;
            fifo_cnt_q   <= fifo_cnt_d;
            strm_rd_q    <= strm_rd_d;
            host_rd_q    <= host_rd_d;
            host_oob_q   <= host_oob_d;
            done_q       <= done_d;
        end
    end

`ifdef CNN_MEM_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic rd_chk;

    // Only words actually consumed are checked; clear-cycle reads are junk.
    assign rd_chk       = (host_rd_q & ~host_oob_q) | strm_rd_q;
    assign parity_err_d = parity_err_q | (rd_chk & (^ram_rdata));
    assign parity_err   = parity_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_cnn_mem_stream.sv
// Directed bench for cnn_mem_stream: host vector table plus stream sequences.
// Parity checks are compiled in with CNN_MEM_PARITY_EN.
module tb_cnn_mem_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [15:0] address = '0, writedata = '0;
    logic [15:0] readdata;
    logic        readdatavalid, waitrequest;
    logic        cnn_start = 1'b0;
    logic [15:0] cnn_base = '0;
    logic [8:0]  cnn_len = '0;
    logic [15:0] cnn_data;
    logic        cnn_valid, cnn_done, busy;
    logic        cnn_ready = 1'b0;
`ifdef CNN_MEM_PARITY_EN
    logic        parity_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] model [256];

    always #5 clk = ~clk;

    cnn_mem_stream dut (
        .clk(clk), .reset(reset),
        .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata),
        .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .cnn_start(cnn_start), .cnn_base(cnn_base), .cnn_len(cnn_len),
        .cnn_data(cnn_data), .cnn_valid(cnn_valid), .cnn_ready(cnn_ready),
        .cnn_done(cnn_done),
`ifdef CNN_MEM_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        string       nm;
    } hvec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic host_write(input logic [15:0] a, input logic [15:0] d);
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        if (a < 16'd256) model[a[7:0]] = d;
    endtask

    task automatic host_read(input logic [15:0] a, input logic [15:0] exp, input string nm);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        check({nm, "_rdv"}, 32'(readdatavalid), 32'd1);
        check({nm, "_data"}, 32'(readdata), 32'(exp));
        @(negedge clk);
        check({nm, "_rdv_off"}, 32'(readdatavalid), 32'd0);
    endtask

    // Counts cycles from reset release until busy drops.
    task automatic wait_clear(input string nm);
        int n = 0;
        bit seen_done = 0;
        reset = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (cnn_done) seen_done = 1;
            if (!busy) break;
        end
        check({nm, "_cycles"}, 32'(n), 32'd256);
        check({nm, "_waitreq"}, 32'(waitrequest), 32'd0);
        check({nm, "_no_done"}, 32'(seen_done), 32'd0);
        for (int i = 0; i < 256; i++) model[i] = 16'h0;
    endtask

    task automatic run_stream(input int base, input int len, input bit toggle,
                              input bit hostrd, input string nm);
        int cyc = 0, got = 0, first = -1, last = -1, done_cyc = -1, nhost = 0;
        bit seen_done = 0, pend = 0;
        logic [15:0] pend_exp = '0;
        logic [7:0]  ha;
        cnn_base = 16'(base); cnn_len = 9'(len); cnn_start = 1'b1; cnn_ready = 1'b1;
        @(negedge clk);
        cnn_start = 1'b0;
        while (!seen_done && cyc < 300) begin
            chipselect = 1'b0; read = 1'b0;
            if (pend) begin
                check({nm, "_host_rdv"}, 32'(readdatavalid), 32'd1);
                check({nm, "_host_data"}, 32'(readdata), 32'(pend_exp));
                pend = 0;
            end
            if (toggle) cnn_ready = (cyc % 2 == 0);
            if (hostrd && (cyc % 2 == 0) && got < len) begin
                ha = 8'(8'h30 + (cyc % 16));
                chipselect = 1'b1; read = 1'b1; address = {8'h00, ha};
                pend = 1; pend_exp = model[ha]; nhost++;
            end
            if (cnn_done) begin
                seen_done = 1; done_cyc = cyc;
            end else if (cnn_valid && cnn_ready) begin
                check($sformatf("%s_beat%0d", nm, got), 32'(cnn_data),
                      32'(model[(base + got) % 256]));
                if (first < 0) first = cyc;
                got++; last = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        chipselect = 1'b0; read = 1'b0;
        check({nm, "_done_seen"}, 32'(seen_done), 32'd1);
        check({nm, "_beats"}, 32'(got), 32'(len));
        check({nm, "_done_after_last"}, 32'(done_cyc), 32'(last + 1));
        if (!toggle && !hostrd)
            check({nm, "_back_to_back"}, 32'(last - first), 32'(len - 1));
        if (hostrd)
            check({nm, "_within_bound"}, 32'(done_cyc <= len + nhost + 2), 32'd1);
        check({nm, "_done_pulse"}, 32'(cnn_done), 32'd0);
        check({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    hvec_t vecs [10];

    initial begin
        int got;
        vecs[0] = '{0, 16'h0042, 16'h0000, "rd42_cleared"};
        vecs[1] = '{1, 16'h0010, 16'hBEEF, "wr10"};
        vecs[2] = '{0, 16'h0010, 16'hBEEF, "rd10"};
        vecs[3] = '{1, 16'h01FF, 16'h1234, "wr1ff_drop"};
        vecs[4] = '{0, 16'h01FF, 16'h0000, "rd1ff_oob"};
        vecs[5] = '{1, 16'h0100, 16'h7777, "wr100_drop"};
        vecs[6] = '{0, 16'h0000, 16'h0000, "rd0_no_alias"};
        vecs[7] = '{1, 16'h00FF, 16'hA5A5, "wrff"};
        vecs[8] = '{0, 16'h00FF, 16'hA5A5, "rdff"};
        vecs[9] = '{0, 16'hFFFF, 16'h0000, "rdffff_oob"};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_waitreq", 32'(waitrequest), 32'd1);
        check("rst_rdv", 32'(readdatavalid), 32'd0);
        check("rst_readdata", 32'(readdata), 32'd0);
        check("rst_valid", 32'(cnn_valid), 32'd0);
        check("rst_done", 32'(cnn_done), 32'd0);
        wait_clear("clear0");

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) host_write(vecs[i].addr, vecs[i].data);
            else            host_read(vecs[i].addr, vecs[i].data, vecs[i].nm);
        end

        // Read and write together: the write lands, no read pulse.
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 16'h0020; writedata = 16'h5A5A;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        model[8'h20] = 16'h5A5A;
        check("rw_both_rdv", 32'(readdatavalid), 32'd0);
        host_read(16'h0020, 16'h5A5A, "rw_both_rd");

        // Zero-length start: done next cycle, stays idle.
        cnn_len = '0; cnn_start = 1'b1;
        @(negedge clk);
        cnn_start = 1'b0;
        check("len0_done", 32'(cnn_done), 32'd1);
        check("len0_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("len0_done_off", 32'(cnn_done), 32'd0);

        for (int i = 0; i < 8; i++) host_write(16'(i), 16'(16'h100 + i));
        run_stream(0, 8, 0, 0, "full");

        host_write(16'd254, 16'h02FE);
        host_write(16'd255, 16'h02FF);
        run_stream(254, 4, 1, 0, "wrap");

        for (int i = 0; i < 16; i++) host_write(16'(16'h30 + i), 16'(16'h300 + i));
        run_stream(16'h30, 16, 0, 1, "contend");

        // Reset on the third beat of a burst.
        cnn_base = '0; cnn_len = 9'd8; cnn_start = 1'b1; cnn_ready = 1'b1;
        @(negedge clk);
        cnn_start = 1'b0;
        got = 0;
        for (int c = 0; c < 50 && got < 3; c++) begin
            if (cnn_valid) begin
                got++;
                if (got == 3) reset = 1'b1;
            end
            if (got < 3) @(negedge clk);
        end
        #1;
        check("mid_rst_reached", 32'(got), 32'd3);
        check("mid_rst_valid", 32'(cnn_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_waitreq", 32'(waitrequest), 32'd1);
        @(negedge clk);
        wait_clear("clear1");
        host_read(16'h0003, 16'h0000, "rd3_recleared");

`ifdef CNN_MEM_PARITY_EN
        check("parity_clean", 32'(parity_err), 32'd0);
        dut.u_ram.mem[5][0] = ~dut.u_ram.mem[5][0];
        host_read(16'h0005, 16'h0001, "rd5_flipped");
        check("parity_err_set", 32'(parity_err), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_mem_stream.md
Name: cnn_mem_stream

Overview:
- Parametrised successor to the CNN weight/image scratch memory.
- Single-port synchronous RAM with three users: a host Avalon-MM slave port for HPS writes and reads, a clear engine that zeroes the RAM after reset, and a burst streaming read port that feeds CNN compute with a valid/ready handshake.
- Sits between the HPS bridge and the CNN datapath.

Parameters:
- DATA_W, 16, RAM word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words; must be a power of 2.
- ADDR_W, 16, host and stream address width; only the low $clog2(DEPTH) bits index the RAM.
- LEN_W, 9, burst length counter width; bursts of up to DEPTH words.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- chipselect  in  1  host select.
- read  in  1  host read strobe.
- write  in  1  host write strobe.
- address  in  ADDR_W  host word address.
- writedata  in  DATA_W  host write data.
- readdata  out  DATA_W  host read data.
- readdatavalid  out  1  one-cycle pulse when readdata is valid.
- waitrequest  out  1  host must hold its request while this is high.
- cnn_start  in  1  burst start pulse, sampled only in IDLE.
- cnn_base  in  ADDR_W  burst start address.
- cnn_len  in  LEN_W  burst length in words.
- cnn_data  out  DATA_W  stream data.
- cnn_valid  out  1  stream data valid.
- cnn_ready  in  1  consumer ready.
- cnn_done  out  1  one-cycle pulse after the final word is accepted.
- busy  out  1  high in CLEAR and STREAM states.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted and after release:
  - state=CLEAR; clr_ptr=0; readdata=0; readdatavalid=0; waitrequest=1; cnn_valid=0; cnn_done=0; busy=1.
  - Output FIFO is emptied and the in-flight counter is 0.
- CLEAR state:
  - Writes 0 to ram[clr_ptr] each cycle and increments clr_ptr.
  - After writing DEPTH-1, goes to IDLE. The clear takes exactly DEPTH cycles.
  - waitrequest=1 throughout CLEAR.
  - Reset asserted mid-clear restarts the clear from 0.
- Host port, in IDLE or STREAM (waitrequest=0):
  - A write (chipselect&write) commits at the clock edge.
  - A read (chipselect&read&!write) returns ram[address] on readdata with readdatavalid=1 exactly one cycle later.
  - If read and write are asserted together, the write wins and readdatavalid is not pulsed.
  - Address >= DEPTH: the write is dropped, and a read returns 0 with readdatavalid pulsed.
- IDLE to STREAM:
  - cnn_start with cnn_len>0 latches the base address and length, then enters STREAM.
  - cnn_start with cnn_len=0 pulses cnn_done on the next cycle and stays in IDLE.
- STREAM state:
  - Issues one RAM read per cycle when no host access occurs that cycle and (FIFO occupancy + in-flight) < 2. The host has priority on the RAM.
  - RAM read latency is 1 cycle. Returned data enters a 2-entry FIFO, and the FIFO head drives cnn_data/cnn_valid.
  - A word transfers when cnn_valid&cnn_ready.
  - Sustained throughput is 1 word/cycle when cnn_ready=1 and there is no host traffic.
  - The address increments modulo DEPTH, so a burst wraps from DEPTH-1 to 0.
  - cnn_start during STREAM is ignored.
  - When the final word transfers, cnn_done=1 for one cycle and the state returns to IDLE on the same edge.
- Ordering:
  - A host write in cycle N is visible to any stream read issued in cycle N+1 or later.
  - The RAM is read-before-write on same-cycle collisions; in practice these cannot occur because the host has priority.
- Width rules:
  - The remaining-word counter is LEN_W bits.
  - cnn_len values greater than DEPTH are allowed and simply wrap repeatedly.

Optional Feature:
- Macro CNN_MEM_PARITY_EN.
- When defined:
  - Each RAM word stores an extra even-parity bit, computed on write; the clear engine writes parity 0.
  - On every read, parity is checked. A mismatch sets a sticky output parity_err (1 bit, reset 0), which is cleared only by reset.
  - The port parity_err exists only when the macro is defined.
- When undefined: no extra storage bit and no parity_err port.

Decomposition:
- Package cnn_mem_pkg holds:
  - state enum typedef (CLEAR, IDLE, STREAM);
  - default DATA_W/DEPTH localparams;
  - parity function.
- One natural sub-module: cnn_mem_ram, a single-port synchronous RAM (1-cycle read, DATA_W+parity wide) so that it infers block RAM.
- The FIFO is inline; it is only 2 entries.

Test Plan:
- Reset release: busy=1 and waitrequest=1 for exactly 256 cycles, then both drop to 0. A host read of address 0x42 then returns 0x0000 with readdatavalid exactly one cycle later.
- Host write/read: write 0xBEEF to 0x10, then read 0x10 → readdata=0xBEEF with readdatavalid 1 cycle later. Write to 0x1FF is dropped; a read of 0x1FF returns 0.
- Full-rate stream: preload addresses 0..7 with values 0x100+i. Start with base=0, len=8, cnn_ready=1 → 8 consecutive cnn_valid beats of 0x100..0x107, then cnn_done pulses one cycle after the last beat is accepted.
- Wrap and backpressure: start with base=254, len=4, and cnn_ready toggling 1/0 → data is ram[254], ram[255], ram[0], ram[1], in order with no loss or duplication.
- Host contention: during a len=16 stream, issue host reads every other cycle → stream data stays correct and in order, every host read returns after 1 cycle, and the stream finishes in no more than 16 plus the number of host reads plus 2 cycles.
- Mid-stream reset: assert reset on the 3rd beat → cnn_valid drops to 0 immediately, the 256-cycle clear reruns, and the state ends in IDLE with no cnn_done pulse. With the CNN_MEM_PARITY_EN macro defined, a forced RAM bit flip sets parity_err on the next read.
